// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - key-entry sequencer building operand A, operator and operand B for the calculator ALU
//
// Ports:
//   clk        system clock (shared with VGA)
//   rst        synchronous active-high reset
//   mode       0 = hex entry, 1 = decimal entry
//   enter      one-cycle pulse, accept val
//   val        key code (0x00-0x0F digit, 0x10-0x17 function, others ignored)
//   result     ALU result for the current op_a/op_b/op_code
//   op_a/op_b  operands presented to the ALU
//   op_code    0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 7 none
//   exe_valid  one-cycle pulse when operands are committed to the ALU
//   display    A in S_A/S_OP, B in S_B, result in S_RES
//   state      0 S_A, 1 S_OP, 2 S_B, 3 S_RES
//   digit_cnt  digits entered into the current operand
module calc_entry_ctrl #(
  parameter int W        = 16,
  parameter int N_DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         enter,
  input  logic [4:0]   val,
  input  logic [W-1:0] result,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [2:0]   op_code,
  output logic         exe_valid,
  output logic [W-1:0] display,
  output logic [1:0]   state,
  output logic [2:0]   digit_cnt
);

  typedef enum logic [1:0] {S_A = 2'd0, S_OP = 2'd1, S_B = 2'd2, S_RES = 2'd3} state_t;

  localparam logic [2:0] MAX_CNT = 3'(N_DIGITS);
  localparam logic [2:0] OP_NONE = 3'd7;

  state_t       st;
  logic         mode_q;
  logic         is_digit, is_op, is_exe, is_ce, is_clr, do_clr;
  logic [2:0]   op_sel;
  logic [W-1:0] dval, a_acc, b_acc;

  // Append one digit to an accumulator; decimal uses acc*8 + acc*2 + d.
  function automatic logic [W-1:0] acc_next(input logic [W-1:0] acc, input logic dec,
                                            input logic [W-1:0] d);
    if (dec) acc_next = (acc << 3) + (acc << 1) + d;
    else     acc_next = {acc[W-5:0], d[3:0]};
  endfunction

  always_comb begin
    op_sel = OP_NONE;
    is_op  = 1'b1;
    case (val)
      5'h10:   op_sel = 3'd0;
      5'h11:   op_sel = 3'd2;
      5'h12:   op_sel = 3'd3;
      5'h14:   op_sel = 3'd1;
      5'h15:   op_sel = 3'd4;
      default: is_op  = 1'b0;
    endcase
    // Decimal mode silently drops A-F keys.
    is_digit = !val[4] && (!mode || val[3:0] <= 4'd9);
    is_exe   = (val == 5'h13);
    is_ce    = (val == 5'h16);
    is_clr   = (val == 5'h17);
    dval     = {{(W-4){1'b0}}, val[3:0]};
    a_acc    = acc_next(op_a, mode, dval);
    b_acc    = acc_next(op_b, mode, dval);
    // A mode change wipes the calculation and takes priority over any key.
    do_clr   = (mode != mode_q) || (enter && (is_clr || (is_ce && st == S_RES)));
  end

  always_ff @(posedge clk) begin
    exe_valid <= 1'b0;
    if (rst || do_clr) begin
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= OP_NONE;
      digit_cnt <= 3'd0;
      st        <= S_A;
      mode_q    <= mode;
    end else if (enter) begin
      case (st)
        S_A: begin
          if (is_digit) begin
            if (digit_cnt != MAX_CNT) begin
              op_a      <= a_acc;
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (is_op) begin
            op_code   <= op_sel;
            digit_cnt <= 3'd0;
            st        <= S_OP;
          end else if (is_ce) begin
            op_a      <= '0;
            digit_cnt <= 3'd0;
          end
        end
        S_OP: begin
          if (is_op) begin
            op_code <= op_sel;
          end else if (is_digit) begin
            op_b      <= dval;
            digit_cnt <= 3'd1;
            st        <= S_B;
          end else if (is_ce) begin
            op_code <= OP_NONE;
            st      <= S_A;
          end
        end
        S_B: begin
          if (is_digit) begin
            if (digit_cnt != MAX_CNT) begin
              op_b      <= b_acc;
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (is_exe) begin
            exe_valid <= 1'b1;
            st        <= S_RES;
          end else if (is_ce) begin
            op_b      <= '0;
            digit_cnt <= 3'd0;
          end
        end
        S_RES: begin
          if (is_digit) begin
            // Fresh calculation starting with this digit.
            op_a      <= dval;
            op_b      <= '0;
            op_code   <= OP_NONE;
            digit_cnt <= 3'd1;
            st        <= S_A;
          end else if (is_op) begin
            // Chain: previous result becomes the new A.
            op_a      <= result;
            op_b      <= '0;
            op_code   <= op_sel;
            digit_cnt <= 3'd0;
            st        <= S_OP;
          end else if (is_exe) begin
            // Repeat last operation on the result.
            op_a      <= result;
            exe_valid <= 1'b1;
          end
        end
        default: st <= S_A;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    case (st)
      S_B:     display = op_b;
      S_RES:   display = result;
      default: display = op_a;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - randomized self-checking bench for calc_entry_ctrl
module tb_calc_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        enter = 1'b0;
  logic [4:0]  val = 5'h1f;
  logic [15:0] result;
  logic [15:0] op_a, op_b, display;
  logic [2:0]  op_code, digit_cnt;
  logic        exe_valid;
  logic [1:0]  state;

  int vectors = 0;
  int errors  = 0;
  logic cur_mode = 1'b0;

  // Reference state: phase 0=A 1=OP 2=B 3=RES
  int m_ph, m_a, m_b, m_op, m_cnt, m_ev;
  logic m_mq;

  calc_entry_ctrl #(.W(16), .N_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .enter(enter), .val(val), .result(result),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .exe_valid(exe_valid),
    .display(display), .state(state), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  function automatic int alu(int a, int b, int op);
    case (op)
      0: return (a + b) & 16'hffff;
      1: return (a - b) & 16'hffff;
      2: return (a * b) & 16'hffff;
      3: return a & b;
      4: return a | b;
      default: return 0;
    endcase
  endfunction

  // ALU stand-in driven from the reference, not from the DUT.
  always_comb result = 16'(alu(m_a, m_b, m_op));

  function automatic int key_op(int k);
    case (k)
      16: return 0;
      17: return 2;
      18: return 3;
      20: return 1;
      21: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic m_clear();
    m_a = 0; m_b = 0; m_op = 7; m_cnt = 0; m_ph = 0;
  endtask

  task automatic model_update(input logic en, input int k, input logic md, input logic r, input int rr);
    bit dig;
    int opk;
    int nxt;
    m_ev = 0;
    dig = (k < 16) && (!md || k <= 9);
    opk = key_op(k);
    if (r || md != m_mq) begin
      m_clear();
      m_mq = md;
    end else if (en) begin
      nxt = md ? ((m_ph == 2 ? m_b : m_a) * 10 + k) % 65536
               : ((m_ph == 2 ? m_b : m_a) * 16 + k) % 65536;
      if (k == 23 || (k == 22 && m_ph == 3)) m_clear();
      else case (m_ph)
        0: if (dig) begin
             if (m_cnt < 4) begin m_a = nxt; m_cnt++; end
           end else if (opk >= 0) begin m_op = opk; m_cnt = 0; m_ph = 1; end
           else if (k == 22) begin m_a = 0; m_cnt = 0; end
        1: if (opk >= 0) m_op = opk;
           else if (dig) begin m_b = k; m_cnt = 1; m_ph = 2; end
           else if (k == 22) begin m_op = 7; m_ph = 0; end
        2: if (dig) begin
             if (m_cnt < 4) begin m_b = nxt; m_cnt++; end
           end else if (k == 19) begin m_ev = 1; m_ph = 3; end
           else if (k == 22) begin m_b = 0; m_cnt = 0; end
        default:
           if (dig) begin m_a = k; m_b = 0; m_op = 7; m_cnt = 1; m_ph = 0; end
           else if (opk >= 0) begin m_a = rr; m_b = 0; m_op = opk; m_cnt = 0; m_ph = 1; end
           else if (k == 19) begin m_a = rr; m_ev = 1; end
      endcase
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int disp;
    disp = (m_ph == 2) ? m_b : (m_ph == 3) ? alu(m_a, m_b, m_op) : m_a;
    chk("op_a", int'(op_a), m_a);
    chk("op_b", int'(op_b), m_b);
    chk("op_code", int'(op_code), m_op);
    chk("exe_valid", int'(exe_valid), m_ev);
    chk("display", int'(display), disp);
    chk("state", int'(state), m_ph);
    chk("digit_cnt", int'(digit_cnt), m_cnt);
  endtask

  task automatic step(input logic en, input logic [4:0] v, input logic md, input logic r);
    int rr;
    @(negedge clk);
    enter = en; val = v; mode = md; rst = r;
    rr = int'(result);
    @(posedge clk);
    #1;
    model_update(en, int'(v), md, r, rr);
    compare_all();
  endtask

  task automatic key(input logic [4:0] v);
    step(1'b1, v, cur_mode, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'h1f, cur_mode, 1'b0);
  endtask

  initial begin
    m_mq = 1'b0;
    m_clear();
    m_ev = 0;
    step(1'b0, 5'h1f, 1'b0, 1'b1);
    step(1'b0, 5'h1f, 1'b0, 1'b1);
    idle();
    chk("rst_op_code", int'(op_code), 7);
    chk("rst_state", int'(state), 0);
    chk("rst_display", int'(display), 0);

    // HEX 1,2,ADD,3,EXE
    key(5'h01); key(5'h02); key(5'h10); key(5'h03); key(5'h13);
    chk("hex_exe_pulse", int'(exe_valid), 1);
    chk("hex_op_a", int'(op_a), 16'h0012);
    chk("hex_op_b", int'(op_b), 16'h0003);
    chk("hex_op_code", int'(op_code), 0);
    chk("hex_state", int'(state), 3);
    idle();
    chk("hex_exe_once", int'(exe_valid), 0);
    chk("hex_display_res", int'(display), 16'h0015);
    // Chain MUL,2,EXE
    key(5'h11); key(5'h02); key(5'h13);
    chk("chain_op_a", int'(op_a), 16'h0015);
    chk("chain_op_b", int'(op_b), 16'h0002);
    chk("chain_op_code", int'(op_code), 2);
    chk("chain_display", int'(display), 16'h002a);

    // DEC 1,2,A,5
    cur_mode = 1'b1; idle();
    key(5'h01); key(5'h02); key(5'h0a); key(5'h05);
    chk("dec_op_a", int'(op_a), 125);
    chk("dec_cnt", int'(digit_cnt), 3);
    chk("dec_state", int'(state), 0);

    // HEX overflow 1,2,3,4,5
    cur_mode = 1'b0; idle();
    key(5'h01); key(5'h02); key(5'h03); key(5'h04); key(5'h05);
    chk("ovf_op_a", int'(op_a), 16'h1234);
    chk("ovf_cnt", int'(digit_cnt), 4);

    // CE in S_B: 7,SUB,9,9,CE,4,EXE
    key(5'h17);
    key(5'h07); key(5'h14); key(5'h09); key(5'h09); key(5'h16); key(5'h04); key(5'h13);
    chk("ce_op_a", int'(op_a), 7);
    chk("ce_op_b", int'(op_b), 4);
    chk("ce_op_code", int'(op_code), 1);
    chk("ce_exe", int'(exe_valid), 1);
    idle();
    chk("ce_exe_once", int'(exe_valid), 0);

    // Mode toggle in S_B
    key(5'h17); key(5'h03); key(5'h10); key(5'h05);
    cur_mode = 1'b1; idle();
    chk("mode_op_a", int'(op_a), 0);
    chk("mode_op_b", int'(op_b), 0);
    chk("mode_op_code", int'(op_code), 7);
    chk("mode_state", int'(state), 0);
    cur_mode = 1'b0; idle();

    // rst with a pending enter
    key(5'h03); key(5'h10); key(5'h05);
    step(1'b1, 5'h06, 1'b0, 1'b1);
    chk("rst_mid_op_b", int'(op_b), 0);
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_cnt", int'(digit_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int pick;
      logic [4:0] v;
      logic en, r;
      pick = int'($urandom_range(0, 99));
      if (pick < 55)      v = 5'($urandom_range(0, 15));
      else if (pick < 92) v = 5'($urandom_range(16, 23));
      else                v = 5'($urandom_range(24, 31));
      en = ($urandom_range(0, 9) < 8);
      r  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) cur_mode = ~cur_mode;
      step(en, v, cur_mode, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
